read_cmd_burst_reader: RTL

// - Downstream consumer of the ram_controller_1 src_read_cmd stream (97-bit AXI-S read commands).
// - Splits each command into Avalon-MM burst reads toward the EMIF/HPS memory path.
// - Buffers returned beats in an internal FIFO and replays them as an AXI-S data stream with tlast per command.
// - Bursts issue only against reserved FIFO credit, so readdatavalid is never back-pressured.

---
 rtl/read_cmd_burst_reader_if.sv | 44 ++++
 rtl/read_cmd_burst_reader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/read_cmd_burst_reader_if.sv
// Bus bundle for the burst reader: command stream in, Avalon-MM read master out,
// data stream out. The reader side uses modport master, its environment uses slave.
interface read_cmd_burst_reader_if #(
    parameter int AVM_ADDR_W = 32,
    parameter int DATA_W     = 128,
    parameter int BC_W       = 5
);
    // Streams (s_cmd_*, m_data_*) transfer on any cycle where valid & ready are both high;
    // valid never waits on ready. Avalon reads are accepted on read & !waitrequest, and
    // readdatavalid cannot be stalled.
    logic [96:0]           s_cmd_tdata;
    logic                  s_cmd_tvalid;
    logic                  s_cmd_tready;

    logic [AVM_ADDR_W-1:0] avm_address;
    logic                  avm_read;
    logic [BC_W-1:0]       avm_burstcount;
    logic                  avm_waitrequest;
    logic [DATA_W-1:0]     avm_readdata;
    logic                  avm_readdatavalid;

    logic [DATA_W-1:0]     m_data_tdata;
    logic                  m_data_tvalid;
    logic                  m_data_tready;
    logic                  m_data_tlast;

    modport master (
        input  s_cmd_tdata, s_cmd_tvalid,
        output s_cmd_tready,
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output m_data_tdata, m_data_tvalid, m_data_tlast,
        input  m_data_tready
    );

    modport slave (
        output s_cmd_tdata, s_cmd_tvalid,
        input  s_cmd_tready,
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  m_data_tdata, m_data_tvalid, m_data_tlast,
        output m_data_tready
    );
endinterface

// File: rtl/read_cmd_burst_reader.sv
// Splits 97-bit read commands into Avalon-MM burst reads issued against reserved FIFO
// credit, and replays the returned beats as a data stream with tlast per command.
module read_cmd_burst_reader #(
    parameter int AVM_ADDR_W = 32,
    parameter int DATA_W     = 128,
    parameter int MAX_BURST  = 16,
    parameter int BC_W       = 5,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    read_cmd_burst_reader_if.master bus,
    output logic                    done_pulse,
    output logic                    busy,
    output logic [1:0]              dbg_state_o
);
    localparam int BPB     = DATA_W / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = 29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AVM_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  done_en_q, done_en_d;
    logic                  done_pulse_q, done_pulse_d;
    logic [PW:0]           wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];

    logic                  cmd_hs, accept, push, pop, fifo_empty, tlast;
    logic [CNT_W-1:0]      burst_beats, cmd_total;
    logic [AVM_ADDR_W-1:0] cmd_addr;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^bus.s_cmd_tdata[63:AVM_ADDR_W];

    assign cmd_addr  = bus.s_cmd_tdata[AVM_ADDR_W-1:0] & ~AVM_ADDR_W'(BPB - 1);
    assign cmd_total = CNT_W'(bus.s_cmd_tdata[95:64] >> LOG_BPB);

    assign bus.s_cmd_tready = (state_q == IDLE) & ~reset;
    assign cmd_hs           = bus.s_cmd_tvalid & bus.s_cmd_tready;

    // A burst is only requested once the FIFO can absorb every beat it returns.
    assign burst_beats        = (remaining_q > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : remaining_q;
    assign bus.avm_read       = (state_q == ISSUE) && (CNT_W'(credits_q) >= burst_beats);
    assign bus.avm_address    = addr_q;
    assign bus.avm_burstcount = (state_q == ISSUE) ? burst_beats[BC_W-1:0] : '0;
    assign accept             = bus.avm_read & ~bus.avm_waitrequest;

    assign push              = bus.avm_readdatavalid;
    assign fifo_empty        = (wr_ptr_q == rd_ptr_q);
    assign bus.m_data_tvalid = ~fifo_empty;
    assign bus.m_data_tdata  = fifo_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
    assign pop               = bus.m_data_tvalid & bus.m_data_tready;
    assign tlast             = bus.m_data_tvalid & (out_cnt_q == total_q - CNT_W'(1));
    assign bus.m_data_tlast  = tlast;

    assign credits_d = credits_q + (pop ? CW'(1) : CW'(0)) - (accept ? CW'(burst_beats) : CW'(0));

    assign done_pulse  = done_pulse_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        total_d      = total_q;
        remaining_d  = remaining_q;
        out_cnt_d    = pop ? out_cnt_q + CNT_W'(1) : out_cnt_q;
        done_en_d    = done_en_q;
        done_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    addr_d      = cmd_addr;
                    total_d     = cmd_total;
                    remaining_d = cmd_total;
                    out_cnt_d   = '0;
                    done_en_d   = bus.s_cmd_tdata[96];
                    // Zero-beat commands complete on the spot.
                    if (cmd_total == '0) done_pulse_d = bus.s_cmd_tdata[96];
                    else                 state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d      = addr_q + (AVM_ADDR_W'(burst_beats) << LOG_BPB);
                    remaining_d = remaining_q - burst_beats;
                    if (remaining_d == '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && tlast) begin
                    state_d      = IDLE;
                    done_pulse_d = done_en_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            total_q      <= '0;
            remaining_q  <= '0;
            out_cnt_q    <= '0;
            credits_q    <= CW'(FIFO_DEPTH);
            done_en_q    <= 1'b0;
            done_pulse_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            total_q      <= total_d;
            remaining_q  <= remaining_d;
            out_cnt_q    <= out_cnt_d;
            credits_q    <= credits_d;
            done_en_q    <= done_en_d;
            done_pulse_q <= done_pulse_d;
            if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // Storage needs no reset: reads are masked while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= bus.avm_readdata;
    end
endmodule
